// File: rtl/ras_pkg.sv
// Return-address-stack checkpoint package: shared widths, types and tag-age helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   STACK_DEPTH / NUM_CKPT  sizes of the controlled stack and of the checkpoint ring
//   TW / GW                 tail and tag widths
//   tail_t / tag_t / ckpt_t stack tail index, checkpoint tag, checkpoint record
//   tag_age()               distance of a tag from the ring head, mod NUM_CKPT
package ras_pkg;

   localparam int STACK_DEPTH = 8;
   localparam int NUM_CKPT    = 8;   // must be a power of 2
   localparam int TW          = $clog2(STACK_DEPTH);
   localparam int GW          = $clog2(NUM_CKPT);

   typedef logic [TW-1:0] tail_t;
   typedef logic [GW-1:0] tag_t;

   typedef struct packed {
      tail_t tail;
   } ckpt_t;

   // GW-bit subtraction wraps naturally, which is the mod NUM_CKPT distance.
   function automatic tag_t tag_age(input tag_t tag, input tag_t head);
      tag_age = tag - head;
   endfunction

endpackage

// File: rtl/ras_ckpt_ctrl_ckpt_ring.sv
// Checkpoint ring storage: NUM_CKPT x TW register file, one write port, one async read port.
// Latency: write lands on the next clk edge; read is combinational.
// Backpressure: none; occupancy is tracked by the owner (ras_ckpt_ctrl).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset (clears all entries)
//   i_wr_en/i_wr_idx/i_wr_dat  allocate-side write
//   i_rd_idx/o_rd_dat       restore-side read
module ckpt_ring
   import ras_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_wr_en,
   input  tag_t  i_wr_idx,
   input  ckpt_t i_wr_dat,
   input  tag_t  i_rd_idx,
   output ckpt_t o_rd_dat
);

   ckpt_t r_mem [NUM_CKPT];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_CKPT; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_dat;
      end
   end

   assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/ras_ckpt_ctrl.sv
// Return-address-stack front-end: call/ret -> push/pop/pushee, per-branch tail checkpoints, mispredict restore.
// Latency: push/pop/pushee/restore/new_tail are combinational in the accepting/resolving cycle; state updates next edge.
// Backpressure: br_ready_out drops when all NUM_CKPT checkpoints are live or a mispredict is resolving this cycle.
//
// Ports:
//   clk_in, rst_in                      clock, synchronous active-high reset
//   br_valid_in/br_ready_out            predicted-branch allocate handshake
//   is_call_in/is_ret_in/call_pc_in     branch kind and call PC
//   br_tag_out                          tag handed to the allocating branch
//   resolve_valid_in/resolve_tag_in/resolve_mispredict_in   branch resolution
//   push_out/pop_out/pushee_out         stack push/pop control
//   restore_tail_out/new_tail_out       stack tail restore
//   count_out                           live checkpoint count
//   error_out                           sticky protocol-violation flag
module ras_ckpt_ctrl
   import ras_pkg::*;
#(
   parameter int ENTRY_SIZE = 64,
   parameter int RET_OFFSET = 4
)
(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  br_valid_in,
   output logic                  br_ready_out,
   input  logic                  is_call_in,
   input  logic                  is_ret_in,
   input  logic [ENTRY_SIZE-1:0] call_pc_in,
   output logic [GW-1:0]         br_tag_out,
   input  logic                  resolve_valid_in,
   input  logic [GW-1:0]         resolve_tag_in,
   input  logic                  resolve_mispredict_in,
   output logic                  push_out,
   output logic                  pop_out,
   output logic [ENTRY_SIZE-1:0] pushee_out,
   output logic                  restore_tail_out,
   output logic [TW-1:0]         new_tail_out,
   output logic [GW:0]           count_out,
   output logic                  error_out
);

   localparam logic [GW:0] FULL_CNT = (GW+1)'(NUM_CKPT);

   tag_t        r_head;
   tag_t        r_alloc;
   logic [GW:0] r_count;
   tail_t       r_shadow;
   logic        r_error;

   logic        w_mis;
   logic        w_free_req;
   tag_t        w_age;
   logic        w_outst;
   logic        w_restore;
   logic        w_free;
   logic        w_bad;
   logic        w_ready;
   logic        w_alloc;
   tail_t       w_tail_next;
   logic [GW:0] w_count_next;
   ckpt_t       w_wr_ckpt;
   ckpt_t       w_rd_ckpt;

   // ------------------------------------------------------------------
   // Resolve classification
   // ------------------------------------------------------------------
   assign w_mis      = resolve_valid_in & resolve_mispredict_in;
   assign w_free_req = resolve_valid_in & ~resolve_mispredict_in;
   assign w_age      = tag_age(resolve_tag_in, r_head);
   assign w_outst    = ({1'b0, w_age} < r_count);
   assign w_restore  = w_mis & w_outst & ~rst_in;
   // With a live ring, age 0 is exactly tag==head; count==0 makes nothing outstanding.
   assign w_free     = w_free_req & w_outst & (resolve_tag_in == r_head);
   assign w_bad      = (w_free_req & ~w_free) | (w_mis & ~w_outst);

   // A resolving mispredict blocks allocation even if it will shrink the ring;
   // a freeing resolve is not bypassed into this cycle's ready.
   assign w_ready = (r_count != FULL_CNT) & ~w_mis & ~rst_in;
   assign w_alloc = br_valid_in & w_ready;

   // Call and ret together (or neither) leave the tail where it was.
   always_comb begin
      w_tail_next = r_shadow;
      if (is_call_in && !is_ret_in) begin
         w_tail_next = r_shadow + tail_t'(1);
      end else if (is_ret_in && !is_call_in) begin
         w_tail_next = r_shadow - tail_t'(1);
      end
   end

   // Same-cycle allocate and free cancel out.
   always_comb begin
      w_count_next = r_count;
      if (w_alloc && !w_free) begin
         w_count_next = r_count + (GW+1)'(1);
      end else if (!w_alloc && w_free) begin
         w_count_next = r_count - (GW+1)'(1);
      end
   end

   assign w_wr_ckpt.tail = w_tail_next;

   ckpt_ring u_ring (
      .i_clk    (clk_in),
      .i_rst    (rst_in),
      .i_wr_en  (w_alloc),
      .i_wr_idx (r_alloc),
      .i_wr_dat (w_wr_ckpt),
      .i_rd_idx (resolve_tag_in),
      .o_rd_dat (w_rd_ckpt)
   );

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_head   <= '0;
         r_alloc  <= '0;
         r_count  <= '0;
         r_shadow <= '0;
         r_error  <= 1'b0;
      end else begin
         if (w_restore) begin
            // Roll back to the mispredicted branch; it stays live until its own free.
            r_shadow <= w_rd_ckpt.tail;
            r_alloc  <= resolve_tag_in + tag_t'(1);
            r_count  <= {1'b0, w_age} + (GW+1)'(1);
         end else begin
            if (w_alloc) begin
               r_shadow <= w_tail_next;
               r_alloc  <= r_alloc + tag_t'(1);
            end
            r_count <= w_count_next;
         end
         if (w_free) begin
            r_head <= r_head + tag_t'(1);
         end
         if (w_bad) begin
            r_error <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign br_ready_out     = w_ready;
   assign br_tag_out       = r_alloc;
   assign push_out         = w_alloc & is_call_in;
   assign pop_out          = w_alloc & is_ret_in;
   assign pushee_out       = rst_in ? '0 : (call_pc_in + ENTRY_SIZE'(RET_OFFSET));
   assign restore_tail_out = w_restore;
   assign new_tail_out     = w_restore ? w_rd_ckpt.tail : '0;
   assign count_out        = r_count;
   assign error_out        = r_error;

endmodule

// File: tb/tb_ras_ckpt_ctrl.sv
// Directed bench for ras_ckpt_ctrl: reset, call pushes, ring fill, mispredict restore, tail wrap, errors, mid-stream reset.
// Latency: inputs driven 1ns after posedge, combinational outputs checked 1ns later, registered ones after next edge.
// Backpressure: br_ready_out checked directly against hand-computed occupancy.
module tb_ras_ckpt_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        br_valid_in;
   logic        br_ready_out;
   logic        is_call_in;
   logic        is_ret_in;
   logic [63:0] call_pc_in;
   logic [2:0]  br_tag_out;
   logic        resolve_valid_in;
   logic [2:0]  resolve_tag_in;
   logic        resolve_mispredict_in;
   logic        push_out;
   logic        pop_out;
   logic [63:0] pushee_out;
   logic        restore_tail_out;
   logic [2:0]  new_tail_out;
   logic [3:0]  count_out;
   logic        error_out;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk_in = ~clk_in;

   ras_ckpt_ctrl #(.ENTRY_SIZE(64), .RET_OFFSET(4)) dut (
      .clk_in                (clk_in),
      .rst_in                (rst_in),
      .br_valid_in           (br_valid_in),
      .br_ready_out          (br_ready_out),
      .is_call_in            (is_call_in),
      .is_ret_in             (is_ret_in),
      .call_pc_in            (call_pc_in),
      .br_tag_out            (br_tag_out),
      .resolve_valid_in      (resolve_valid_in),
      .resolve_tag_in        (resolve_tag_in),
      .resolve_mispredict_in (resolve_mispredict_in),
      .push_out              (push_out),
      .pop_out               (pop_out),
      .pushee_out            (pushee_out),
      .restore_tail_out      (restore_tail_out),
      .new_tail_out          (new_tail_out),
      .count_out             (count_out),
      .error_out             (error_out)
   );

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle;
      br_valid_in = 0; is_call_in = 0; is_ret_in = 0; call_pc_in = '0;
      resolve_valid_in = 0; resolve_tag_in = '0; resolve_mispredict_in = 0;
   endtask

   task automatic drive_br(input logic call, input logic ret, input logic [63:0] pc);
      br_valid_in = 1; is_call_in = call; is_ret_in = ret; call_pc_in = pc;
   endtask

   task automatic drive_res(input logic [2:0] tag, input logic mis);
      resolve_valid_in = 1; resolve_tag_in = tag; resolve_mispredict_in = mis;
   endtask

   task automatic apply_reset;
      idle(); rst_in = 1;
      tick(); tick();
      rst_in = 0;
      tick();
   endtask

   // one accepted branch per call, then inputs idle
   task automatic issue(input logic call, input logic ret, input logic [63:0] pc);
      drive_br(call, ret, pc);
      #1;
      tick();
      idle();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      idle(); rst_in = 1;
      drive_br(1, 0, 64'h40);
      tick(); #1;
      n_run++; if (push_out !== 1'b0) begin n_fail++; $display("FAIL rst_push got %0h exp 0", push_out); end
      n_run++; if (br_ready_out !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %0h exp 0", br_ready_out); end
      tick();
      rst_in = 0; idle();
      tick();
      n_run++; if (br_ready_out !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %0h exp 1", br_ready_out); end
      n_run++; if (count_out !== 4'd0) begin n_fail++; $display("FAIL post_rst_count got %0h exp 0", count_out); end
      n_run++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL post_rst_error got %0h exp 0", error_out); end
      n_run++; if (br_tag_out !== 3'd0) begin n_fail++; $display("FAIL post_rst_tag got %0h exp 0", br_tag_out); end
   endtask

   task automatic test_calls;
      logic [63:0] pcs [3];
      pcs[0] = 64'h100; pcs[1] = 64'h200; pcs[2] = 64'h300;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive_br(1, 0, pcs[i]);
         #1;
         n_run++; if (push_out !== 1'b1) begin n_fail++; $display("FAIL call%0d_push got %0h exp 1", i, push_out); end
         n_run++; if (pop_out !== 1'b0) begin n_fail++; $display("FAIL call%0d_pop got %0h exp 0", i, pop_out); end
         n_run++; if (pushee_out !== pcs[i] + 64'd4) begin n_fail++; $display("FAIL call%0d_pushee got %0h exp %0h", i, pushee_out, pcs[i] + 64'd4); end
         n_run++; if (br_tag_out !== 3'(i)) begin n_fail++; $display("FAIL call%0d_tag got %0h exp %0h", i, br_tag_out, i); end
         tick();
         idle();
         #1;
         n_run++; if (push_out !== 1'b0) begin n_fail++; $display("FAIL call%0d_idle_push got %0h exp 0", i, push_out); end
      end
      n_run++; if (count_out !== 4'd3) begin n_fail++; $display("FAIL calls_count got %0h exp 3", count_out); end
      // Snapshots are 1/2/3: walk back youngest-first so each tag stays outstanding.
      for (int t = 2; t >= 0; t--) begin
         drive_res(3'(t), 1);
         #1;
         n_run++; if (restore_tail_out !== 1'b1) begin n_fail++; $display("FAIL snap%0d_restore got %0h exp 1", t, restore_tail_out); end
         n_run++; if (new_tail_out !== 3'(t + 1)) begin n_fail++; $display("FAIL snap%0d_tail got %0h exp %0h", t, new_tail_out, t + 1); end
         tick();
         idle();
         n_run++; if (count_out !== 4'(t + 1)) begin n_fail++; $display("FAIL snap%0d_count got %0h exp %0h", t, count_out, t + 1); end
      end
   endtask

   task automatic test_fill;
      apply_reset();
      for (int i = 0; i < 8; i++) issue(0, 0, 64'h0);
      n_run++; if (count_out !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0h exp 8", count_out); end
      n_run++; if (br_ready_out !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %0h exp 0", br_ready_out); end
      drive_res(3'd0, 0);
      #1;
      n_run++; if (br_ready_out !== 1'b0) begin n_fail++; $display("FAIL fill_nobypass_ready got %0h exp 0", br_ready_out); end
      tick();
      idle();
      n_run++; if (br_ready_out !== 1'b1) begin n_fail++; $display("FAIL free_ready got %0h exp 1", br_ready_out); end
      n_run++; if (count_out !== 4'd7) begin n_fail++; $display("FAIL free_count got %0h exp 7", count_out); end
      n_run++; if (br_tag_out !== 3'd0) begin n_fail++; $display("FAIL free_tag got %0h exp 0", br_tag_out); end
   endtask

   task automatic test_mispredict;
      apply_reset();
      issue(1, 0, 64'h10);   // tag0 tail1
      issue(1, 0, 64'h20);   // tag1 tail2
      issue(0, 0, 64'h0);    // tag2 tail2
      drive_br(0, 1, 64'h0); // tag3 tail1
      #1;
      n_run++; if (pop_out !== 1'b1) begin n_fail++; $display("FAIL ret_pop got %0h exp 1", pop_out); end
      tick(); idle();
      issue(1, 0, 64'h30);   // tag4 tail2
      drive_res(3'd2, 1);
      #1;
      n_run++; if (restore_tail_out !== 1'b1) begin n_fail++; $display("FAIL mis_restore got %0h exp 1", restore_tail_out); end
      n_run++; if (new_tail_out !== 3'd2) begin n_fail++; $display("FAIL mis_newtail got %0h exp 2", new_tail_out); end
      tick();
      idle();
      n_run++; if (count_out !== 4'd3) begin n_fail++; $display("FAIL mis_count got %0h exp 3", count_out); end
      n_run++; if (br_tag_out !== 3'd3) begin n_fail++; $display("FAIL mis_nexttag got %0h exp 3", br_tag_out); end
      // shadow restored to 2, so the next call snapshots 3
      issue(1, 0, 64'h40);
      drive_res(3'd3, 1);
      #1;
      n_run++; if (new_tail_out !== 3'd3) begin n_fail++; $display("FAIL mis_shadow got %0h exp 3", new_tail_out); end
      tick(); idle();
   endtask

   task automatic test_wrap;
      apply_reset();
      for (int i = 0; i < 9; i++) begin
         drive_br(1, 0, 64'h1000);
         if (i > 0) drive_res(3'(i - 1), 0);
         #1;
         tick();
         idle();
      end
      n_run++; if (count_out !== 4'd1) begin n_fail++; $display("FAIL wrap_count got %0h exp 1", count_out); end
      n_run++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL wrap_error got %0h exp 0", error_out); end
      drive_res(3'd0, 1);
      #1;
      n_run++; if (new_tail_out !== 3'd1) begin n_fail++; $display("FAIL wrap_up_tail got %0h exp 1", new_tail_out); end
      tick(); idle();
      apply_reset();
      issue(0, 1, 64'h0);
      drive_res(3'd0, 1);
      #1;
      n_run++; if (new_tail_out !== 3'd7) begin n_fail++; $display("FAIL wrap_down_tail got %0h exp 7", new_tail_out); end
      tick(); idle();
   endtask

   task automatic test_errors;
      apply_reset();
      drive_res(3'd0, 0);    // count==0: nothing outstanding
      #1; tick(); idle();
      n_run++; if (error_out !== 1'b1) begin n_fail++; $display("FAIL empty_free_error got %0h exp 1", error_out); end
      apply_reset();
      issue(0, 0, 64'h0);
      issue(0, 0, 64'h0);
      drive_res(3'd1, 0);
      #1; tick(); idle();
      n_run++; if (error_out !== 1'b1) begin n_fail++; $display("FAIL order_error got %0h exp 1", error_out); end
      n_run++; if (count_out !== 4'd2) begin n_fail++; $display("FAIL order_count got %0h exp 2", count_out); end
      drive_res(3'd5, 1);
      #1;
      n_run++; if (restore_tail_out !== 1'b0) begin n_fail++; $display("FAIL freetag_restore got %0h exp 0", restore_tail_out); end
      tick(); idle();
      n_run++; if (count_out !== 4'd2) begin n_fail++; $display("FAIL freetag_count got %0h exp 2", count_out); end
   endtask

   task automatic test_back_to_back;
      apply_reset();
      issue(1, 0, 64'h500);  // tag0 tail1
      issue(1, 0, 64'h600);  // tag1 tail2
      drive_br(1, 0, 64'h700);
      drive_res(3'd0, 1);
      #1;
      n_run++; if (br_ready_out !== 1'b0) begin n_fail++; $display("FAIL b2b_ready got %0h exp 0", br_ready_out); end
      n_run++; if (push_out !== 1'b0) begin n_fail++; $display("FAIL b2b_push got %0h exp 0", push_out); end
      n_run++; if (new_tail_out !== 3'd1) begin n_fail++; $display("FAIL b2b_newtail got %0h exp 1", new_tail_out); end
      tick(); idle();
      n_run++; if (count_out !== 4'd1) begin n_fail++; $display("FAIL b2b_count got %0h exp 1", count_out); end
      n_run++; if (br_tag_out !== 3'd1) begin n_fail++; $display("FAIL b2b_tag got %0h exp 1", br_tag_out); end
      issue(1, 0, 64'h800);
      // reset lands mid-stream with activity on every input
      rst_in = 1;
      drive_br(1, 0, 64'h900);
      drive_res(3'd0, 1);
      #1;
      n_run++; if (push_out !== 1'b0) begin n_fail++; $display("FAIL midrst_push got %0h exp 0", push_out); end
      n_run++; if (restore_tail_out !== 1'b0) begin n_fail++; $display("FAIL midrst_restore got %0h exp 0", restore_tail_out); end
      n_run++; if (pushee_out !== 64'd0) begin n_fail++; $display("FAIL midrst_pushee got %0h exp 0", pushee_out); end
      tick();
      rst_in = 0; idle();
      #1;
      n_run++; if (count_out !== 4'd0) begin n_fail++; $display("FAIL midrst_count got %0h exp 0", count_out); end
      n_run++; if (br_tag_out !== 3'd0) begin n_fail++; $display("FAIL midrst_tag got %0h exp 0", br_tag_out); end
      n_run++; if (br_ready_out !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %0h exp 1", br_ready_out); end
   endtask

   initial begin
      rst_in = 1;
      idle();
      test_reset();
      test_calls();
      test_fill();
      test_mispredict();
      test_wrap();
      test_errors();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
